// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
//   Shared types and helpers for the round-robin mux arbiter.
//   - state_t   : arbiter FSM encoding (IDLE / OWNED)
//   - N_REQ     : number of requesters sharing the mux
//   - pick_t    : result of a rotate-priority search (found flag + index)
//   - first_from: first set bit of a vector, searching upward from a start index with wrap
//   - onehot4   : 2-bit index to 4-bit one-hot
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Walking the offsets from highest to lowest lets the closest hit to
  // start overwrite any farther one, so no priority flag is needed.
  function automatic pick_t first_from(input logic [N_REQ-1:0] vec,
                                       input logic [1:0]       start);
    pick_t      r;
    logic [1:0] k;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = start + 2'(i);
      if (vec[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
//   Request/grant bundle between the requesters and the arbiter.
//   req[3:0]   requester -> arbiter, level request
//   done[3:0]  requester -> arbiter, release strobe (owner's bit only)
//   grant[3:0] arbiter -> requesters, one-hot grant, zero when idle
//   sel[1:0]   arbiter -> mux select, index of the owner
//   busy       arbiter -> requesters, any grant active
//   preempt    arbiter -> requesters, one-cycle forced-rotation pulse
//   modport master: requester side; modport slave: arbiter side.
interface mux_rr_arbiter_if;
  import mux_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic [1:0]       sel;
  logic             busy;
  logic             preempt;

  modport master (
    output req, done,
    input  grant, sel, busy, preempt
  );

  modport slave (
    input  req, done,
    output grant, sel, busy, preempt
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// rr_pick4
//   Combinational rotate-priority encoder over four candidates.
//   vec[3:0]  candidate bits (already masked by the caller)
//   start[1:0] index searched first; search proceeds upward with wrap
//   idx[1:0]  index of the winner (meaningless when valid=0)
//   valid     at least one candidate bit set
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [1:0]       start,
  output logic [1:0]       idx,
  output logic             valid
);

  pick_t pick;

  assign pick  = first_from(vec, start);
  assign idx   = pick.idx;
  assign valid = pick.found;

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter sharing one 4:1 single-bit mux among four requesters.
//   The owner keeps the mux until it drops req or pulses done; with
//   MAX_HOLD != 0 an owner is rotated out after MAX_HOLD cycles if someone
//   else is waiting. All outputs are registered.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux_rr_arbiter_if.slave (req, done in; grant, sel, busy, preempt out)
//
//   state | meaning
//   IDLE  | no owner; grant=0, busy=0, sel keeps previous owner
//   OWNED | sel names the owner; grant one-hot, busy=1
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_TOP =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       last;
  logic [CNT_W-1:0] hold_cnt;
  logic [N_REQ-1:0] grant_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic             preempt_q;

  logic [N_REQ-1:0] others;
  logic             limit_hit;
  logic             preempt_cond;
  logic             release_now;
  logic [N_REQ-1:0] pick_vec;
  logic [1:0]       pick_start;
  logic [1:0]       pick_idx;
  logic             pick_valid;

  // In OWNED, sel_q is the owner index.
  assign others       = bus.req & ~onehot4(sel_q);
  assign limit_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_TOP);
  assign preempt_cond = limit_hit && (others != '0);
  assign release_now  = !bus.req[sel_q] || bus.done[sel_q] || preempt_cond;

  // One encoder serves both the idle pick and the hand-off pick; on a
  // hand-off the owner's own bit is masked so it cannot win itself back.
  assign pick_vec   = (state == IDLE) ? bus.req : others;
  assign pick_start = (state == IDLE) ? last + 2'd1 : sel_q + 2'd1;

  rr_pick4 u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 2'd3;
      hold_cnt  <= '0;
      grant_q   <= '0;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_q  <= onehot4(pick_idx);
            sel_q    <= pick_idx;
            last     <= pick_idx;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
            state    <= OWNED;
          end
        end
        OWNED: begin
          if (release_now) begin
            // Only a pure hold-limit release counts as preemption.
            preempt_q <= bus.req[sel_q] && !bus.done[sel_q] && preempt_cond;
            hold_cnt  <= '0;
            if (pick_valid) begin
              grant_q <= onehot4(pick_idx);
              sel_q   <= pick_idx;
              last    <= pick_idx;
            end else begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end
          end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_TOP)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Directed bench for mux_rr_arbiter (MAX_HOLD=8, CNT_W=4). Inputs change
//   1 time unit after a rising edge; outputs are sampled at the same point.
module tb_mux_rr_arbiter;
  import mux_rr_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.grant !== 4'b0000) begin
      bad++; $display("FAIL reset_grant got=%b want=0000", bus.grant);
    end
    total++;
    if (bus.sel !== 2'b00) begin
      bad++; $display("FAIL reset_sel got=%b want=00", bus.sel);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.preempt !== 1'b0) begin
      bad++; $display("FAIL reset_flags busy=%b preempt=%b want=0/0", bus.busy, bus.preempt);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    step();
    total++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'b00 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL single_grant grant=%b sel=%b busy=%b want=0001/00/1",
                      bus.grant, bus.sel, bus.busy);
    end
    bus.req = 4'b0000;
    step();
    total++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_release grant=%b busy=%b want=0000/0", bus.grant, bus.busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5];
    logic [1:0] exp_s [5];
    exp_g[0] = 4'b0001; exp_s[0] = 2'd0;
    exp_g[1] = 4'b0010; exp_s[1] = 2'd1;
    exp_g[2] = 4'b0100; exp_s[2] = 2'd2;
    exp_g[3] = 4'b1000; exp_s[3] = 2'd3;
    exp_g[4] = 4'b0001; exp_s[4] = 2'd0;
    do_reset();
    bus.req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (bus.grant !== exp_g[k] || bus.sel !== exp_s[k] || bus.busy !== 1'b1
          || bus.preempt !== 1'b0) begin
        bad++; $display("FAIL rotation_%0d grant=%b sel=%0d busy=%b preempt=%b want=%b/%0d/1/0",
                        k, bus.grant, bus.sel, bus.busy, bus.preempt, exp_g[k], exp_s[k]);
      end
      if (k < 4) begin
        step();
        bus.done = exp_g[k];
        step();
        bus.done = 4'b0000;
      end
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_preempt();
    do_reset();
    bus.req = 4'b0011;
    step();
    total++;
    if (bus.grant !== 4'b0001) begin
      bad++; $display("FAIL preempt_first grant=%b want=0001", bus.grant);
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      total++;
      if (bus.grant !== 4'b0001 || bus.preempt !== 1'b0) begin
        bad++; $display("FAIL preempt_hold_%0d grant=%b preempt=%b want=0001/0",
                        i, bus.grant, bus.preempt);
      end
    end
    step();
    total++;
    if (bus.grant !== 4'b0010 || bus.sel !== 2'b01 || bus.preempt !== 1'b1) begin
      bad++; $display("FAIL preempt_rotate grant=%b sel=%b preempt=%b want=0010/01/1",
                      bus.grant, bus.sel, bus.preempt);
    end
    step();
    total++;
    if (bus.grant !== 4'b0010 || bus.preempt !== 1'b0) begin
      bad++; $display("FAIL preempt_pulse grant=%b preempt=%b want=0010/0",
                      bus.grant, bus.preempt);
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_lone();
    do_reset();
    bus.req = 4'b0100;
    step();
    for (int i = 0; i < 20; i++) begin
      total++;
      if (bus.grant !== 4'b0100 || bus.preempt !== 1'b0) begin
        bad++; $display("FAIL lone_%0d grant=%b preempt=%b want=0100/0",
                        i, bus.grant, bus.preempt);
      end
      step();
    end
    total++;
    if (dut.hold_cnt !== 4'd7) begin
      bad++; $display("FAIL lone_hold_cnt got=%0d want=7", dut.hold_cnt);
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_noise();
    do_reset();
    bus.req = 4'b0010;
    step();
    bus.done = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.grant !== 4'b0010 || bus.busy !== 1'b1 || bus.sel !== 2'b01) begin
        bad++; $display("FAIL noise_%0d grant=%b busy=%b sel=%b want=0010/1/01",
                        i, bus.grant, bus.busy, bus.sel);
      end
    end
    bus.done = 4'b0000;
    bus.req  = 4'b0000;
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    step();
    bus.req = 4'b1101;
    step();
    total++;
    if (bus.grant !== 4'b0100 || bus.sel !== 2'b10) begin
      bad++; $display("FAIL simult_winner grant=%b sel=%b want=0100/10", bus.grant, bus.sel);
    end
    bus.req = 4'b0000;
    step();
    total++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== 2'b10) begin
      bad++; $display("FAIL simult_idle_sel grant=%b busy=%b sel=%b want=0000/0/10",
                      bus.grant, bus.busy, bus.sel);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0100;
    step();
    total++;
    if (bus.grant !== 4'b0100) begin
      bad++; $display("FAIL areset_owner grant=%b want=0100", bus.grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.grant !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL areset_clear grant=%b sel=%b busy=%b want=0000/00/0",
                      bus.grant, bus.sel, bus.busy);
    end
    bus.req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'b00) begin
      bad++; $display("FAIL areset_resume grant=%b sel=%b want=0001/00", bus.grant, bus.sel);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_preempt();
    test_lone();
    test_noise();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux between four requesters.
- Issues a one-hot grant and drives the mux select so that the granted requester's input reaches the mux output.
- Holds a grant until the owner releases it. An optional hold-limit forces rotation when other requesters are waiting.
- Sits directly in front of the mux: its sel output wires straight to the mux select input.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the mux while another request is pending. 0 disables preemption.
- CNT_W, default 4: width of the hold counter. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; level-sensitive.
- done  input  4  release strobe per requester; only the current owner's bit is honoured.
- grant  output  4  one-hot grant; registered; all zero when idle.
- sel  output  2  mux select = index of the owner; registered.
- busy  output  1  high while any grant is active.
- preempt  output  1  one-cycle pulse on the edge where an owner is forcibly rotated out.

Behaviour:
- Reset (async, rst_n=0):
  - grant=0000, sel=00, busy=0, preempt=0, hold_cnt=0.
  - Round-robin pointer last=3, so requester 0 has first priority after reset.
  - State IDLE.
- States: IDLE, OWNED. All outputs are registered; no combinational path from req/done to the outputs.
- IDLE:
  - If req!=0 at a rising edge, grant the first set bit searching from (last+1) mod 4 upward with wrap.
  - Same edge: grant, sel, busy=1 and last=winner update; go to OWNED; hold_cnt=0.
  - Latency: request sampled at edge N, grant visible after edge N (one cycle from assertion).
- OWNED, release condition, evaluated each edge for owner o:
  - req[o]=0, or done[o]=1, or a preempt condition (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~onehot(o))!=0).
- OWNED, on release:
  - Re-arbitrate on the same edge over req with the owner's bit masked, searching from (o+1) mod 4.
  - If a winner exists: hand off with no idle cycle; grant/sel/last update; hold_cnt=0; stay OWNED.
  - If no winner: grant=0000, busy=0, go to IDLE. sel holds its last value.
  - preempt=1 for exactly one cycle only when the release cause was the hold limit (req[o]=1 and done[o]=0).
- OWNED, no release: hold_cnt increments and saturates at MAX_HOLD-1 while no one else is waiting. The grant is kept indefinitely if the owner stays alone.
- done bits of non-owners are ignored. done of the owner while req[o]=0 is the same as a single release.
- An owner re-requesting after release gets the grant back only if no other request is pending. Fairness bound: at most 3 other grants before any waiting requester is served.
- Simultaneous new requests: strict rotation order from last+1. Example: last=1, req=1101 → winner 2.
- Invariants: grant is always one-hot or zero; sel equals the index of the grant bit whenever busy=1.
- Reset mid-grant: all outputs return to reset values immediately (asynchronous); arbitration resumes from priority 0 after rst_n deasserts.

Decomposition:
- Shared package: localparams for state encoding (IDLE=1'b0, OWNED=1'b1) and the requester count N_REQ=4. The function first_from(vector, start) → 2-bit index with found flag belongs alongside them.
- One natural sub-module: rr_pick4, a combinational masked rotate-priority encoder. Inputs are a 4-bit vector and a 2-bit start; outputs are a 2-bit index and a valid flag.
- The top level holds the FSM, pointer, hold counter and output registers.

Test Plan:
- Reset then req=0001 → after one edge grant=0001, sel=00, busy=1. Drop req → next edge grant=0000, busy=0.
- After reset, req=1111 held, each owner pulses done after 2 cycles → grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycle between owners.
- MAX_HOLD=8, req=0011, owner 0 never asserts done → grant moves to 0010 after 8 cycles of ownership, preempt high exactly 1 cycle, sel=01.
- Lone requester: req=0100 held 20 cycles, MAX_HOLD=8 → grant stays 0100 throughout, preempt never asserted, hold_cnt saturates at 7.
- Non-owner noise: owner 1 active, done=1101 pulsed → no change, grant=0010 held.
- Async reset mid-grant: owner 2 active, rst_n low between edges → grant=0000, sel=00, busy=0 without a clock edge. After release with req=1111 → first grant 0001.
